// File: rtl/sram_pkg.sv
// Shared constants and helpers for the SRAM round-robin arbiter.
package sram_pkg;

    localparam int unsigned W_DEF = 8;
    localparam int unsigned D_DEF = 16;
    localparam int unsigned N_DEF = 2;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Position of the set bit in a one-hot vector of up to 8 requesters.
    function automatic int unsigned onehot_idx(input logic [7:0] v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[3'(i)]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_pick
    import sram_pkg::*;
#(
    parameter int unsigned n  = 2,
    parameter int unsigned pw = 1
) (
    input  logic [n-1:0]  req,
    input  logic [pw-1:0] ptr,
    output logic [n-1:0]  gnt,
    output logic [pw-1:0] winner,
    output logic          any
);

    logic          found;
    int unsigned   idx;
    logic [pw-1:0] idx_w;

    // Scan from ptr with an explicit wrap so non-power-of-2 n works.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned k = 0; k < n; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) idx = idx - n;
            idx_w = pw'(idx);
            if (!found && req[idx_w]) begin
                gnt[idx_w] = 1'b1;
                found      = 1'b1;
            end
        end
        winner = pw'(onehot_idx(8'(gnt)));
        any    = |req;
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read single-port SRAM.
module sram_rr_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned w = W_DEF,
    parameter int unsigned d = D_DEF,
    parameter int unsigned n = N_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [n-1:0]               req,
    input  logic [n-1:0]               we,
    input  logic [n*addr_w(d)-1:0]     addr,
    input  logic [n*w-1:0]             wdata,
    output logic [n-1:0]               gnt,
    output logic [n-1:0]               rvalid,
    output logic [w-1:0]               rdata,
    output logic                       mem_w_en,
    output logic [addr_w(d)-1:0]       mem_ad,
    output logic [w-1:0]               mem_data_in,
    input  logic [w-1:0]               mem_data_out
);

    localparam int unsigned aw = addr_w(d);
    localparam int unsigned pw = addr_w(n);

    logic [n-1:0]  req_live;
    logic [pw-1:0] ptr;
    logic [pw-1:0] ptr_nxt;
    logic [pw-1:0] winner;
    logic          any_req;
    logic [aw-1:0] ad_q;
    logic [w-1:0]  wd_q;
    logic          rd_valid;
    logic [pw-1:0] rd_idx;

    // No grant can be issued while reset is held, whatever req says.
    assign req_live = rst_n ? req : '0;

    rr_pick #(
        .n  (n),
        .pw (pw)
    ) u_pick (
        .req    (req_live),
        .ptr    (ptr),
        .gnt    (gnt),
        .winner (winner),
        .any    (any_req)
    );

    // Steer the winner onto the SRAM port; hold the last address/data when idle.
    always_comb begin
        mem_ad      = ad_q;
        mem_data_in = wd_q;
        mem_w_en    = 1'b0;
        ptr_nxt     = ptr;
        if (any_req) begin
            mem_ad      = addr[32'(winner)*aw +: aw];
            mem_data_in = wdata[32'(winner)*w +: w];
            mem_w_en    = we[winner];
            ptr_nxt     = (32'(winner) == n - 1) ? '0 : winner + pw'(1);
        end
    end

    // Pointer, held SRAM port values and the pending-read tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            ad_q     <= '0;
            wd_q     <= '0;
            rd_valid <= 1'b0;
            rd_idx   <= '0;
        end else if (any_req) begin
            ptr      <= ptr_nxt;
            ad_q     <= mem_ad;
            wd_q     <= mem_data_in;
            rd_valid <= ~we[winner];
            rd_idx   <= winner;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Decode the registered tag into the one-hot read strobe.
    always_comb begin
        rvalid = '0;
        if (rd_valid) rvalid[rd_idx] = 1'b1;
    end

    assign rdata = mem_data_out;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench: two arbiter instances (n=2, n=3) each with a behavioural SRAM.
module tb_sram_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance a: n = 2
    logic [1:0]  req_a, we_a, gnt_a, rvalid_a;
    logic [7:0]  addr_a;
    logic [15:0] wdata_a;
    logic [7:0]  rdata_a, din_a, dout_a;
    logic        wen_a;
    logic [3:0]  ad_a;

    // Instance b: n = 3
    logic [2:0]  req_b, we_b, gnt_b, rvalid_b;
    logic [11:0] addr_b;
    logic [23:0] wdata_b;
    logic [7:0]  rdata_b, din_b, dout_b;
    logic        wen_b;
    logic [3:0]  ad_b;

    sram_rr_arbiter #(.w(8), .d(16), .n(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a),
        .mem_w_en(wen_a), .mem_ad(ad_a), .mem_data_in(din_a), .mem_data_out(dout_a)
    );

    sram_rr_arbiter #(.w(8), .d(16), .n(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .mem_w_en(wen_b), .mem_ad(ad_b), .mem_data_in(din_b), .mem_data_out(dout_b)
    );

    function automatic logic [7:0] fill(input int a);
        return 8'((a * 19) ^ 8'h5A);
    endfunction

    // Behavioural synchronous-read SRAMs; contents refilled while reset is low.
    logic [7:0] sram_a [16];
    logic [7:0] sram_b [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                sram_a[i] <= fill(i);
                sram_b[i] <= fill(i);
            end
        end else begin
            if (wen_a) sram_a[ad_a] <= din_a;
            if (wen_b) sram_b[ad_b] <= din_b;
        end
        dout_a <= sram_a[ad_a];
        dout_b <= sram_b[ad_b];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state, one slot per instance.
    int         m_ptr [2];
    bit         m_pend [2];
    int         m_pidx [2];
    logic [7:0] m_pdat [2];
    logic [7:0] m_mem [2][16];
    bit         m_last_ok [2];
    logic [3:0] m_last_ad [2];
    logic [7:0] m_last_din [2];

    // Compare one instance against the model, then advance the model for the coming edge.
    task automatic model_step(input int inst, input int nn, input string tag,
                              input logic [7:0] reqv, input logic [7:0] wev,
                              input logic [31:0] addrv, input logic [63:0] wdv,
                              input logic [7:0] gntv, input logic [7:0] rvv,
                              input logic [7:0] rdv, input logic wen,
                              input logic [3:0] ad, input logic [7:0] din);
        int win;
        int idx;
        logic [3:0] a;
        logic [7:0] wd;
        if (!rst_n) begin
            chk({tag, ".rst_gnt"}, 32'(gntv), 32'd0);
            chk({tag, ".rst_rvalid"}, 32'(rvv), 32'd0);
            chk({tag, ".rst_wen"}, 32'(wen), 32'd0);
            m_ptr[inst] = 0;
            m_pend[inst] = 1'b0;
            m_last_ok[inst] = 1'b0;
            for (int i = 0; i < 16; i++) m_mem[inst][i] = fill(i);
            return;
        end
        chk({tag, ".rvalid"}, 32'(rvv), m_pend[inst] ? 32'(1 << m_pidx[inst]) : 32'd0);
        if (m_pend[inst]) chk({tag, ".rdata"}, 32'(rdv), 32'(m_pdat[inst]));
        win = -1;
        for (int k = 0; k < nn; k++) begin
            idx = (m_ptr[inst] + k) % nn;
            if (win < 0 && reqv[idx]) win = idx;
        end
        chk({tag, ".gnt"}, 32'(gntv), (win >= 0) ? 32'(1 << win) : 32'd0);
        if (win >= 0) begin
            a  = addrv[win*4 +: 4];
            wd = wdv[win*8 +: 8];
            chk({tag, ".mem_ad"}, 32'(ad), 32'(a));
            chk({tag, ".mem_w_en"}, 32'(wen), 32'(wev[win]));
            chk({tag, ".mem_data_in"}, 32'(din), 32'(wd));
            m_ptr[inst] = (win + 1) % nn;
            if (wev[win]) begin
                m_mem[inst][a] = wd;
                m_pend[inst] = 1'b0;
            end else begin
                m_pend[inst] = 1'b1;
                m_pidx[inst] = win;
                m_pdat[inst] = m_mem[inst][a];
            end
            m_last_ok[inst] = 1'b1;
            m_last_ad[inst] = a;
            m_last_din[inst] = wd;
        end else begin
            chk({tag, ".idle_wen"}, 32'(wen), 32'd0);
            if (m_last_ok[inst]) begin
                chk({tag, ".hold_ad"}, 32'(ad), 32'(m_last_ad[inst]));
                chk({tag, ".hold_din"}, 32'(din), 32'(m_last_din[inst]));
            end
            m_pend[inst] = 1'b0;
        end
    endtask

    // Every-cycle comparison on the falling edge, inputs are stable here.
    always @(negedge clk) begin
        model_step(0, 2, "a", 8'(req_a), 8'(we_a), 32'(addr_a), 64'(wdata_a),
                   8'(gnt_a), 8'(rvalid_a), rdata_a, wen_a, ad_a, din_a);
        model_step(1, 3, "b", 8'(req_b), 8'(we_b), 32'(addr_b), 64'(wdata_b),
                   8'(gnt_b), 8'(rvalid_b), rdata_b, wen_b, ad_b, din_b);
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        int cnt [3];
        rst_n = 1'b0;
        req_a = 2'b11; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b = 3'b111; we_b = '0; addr_b = '0; wdata_b = '0;

        repeat (3) next_cyc();
        @(negedge clk);
        chk("t1.gnt_in_reset", 32'(gnt_a), 32'd0);
        chk("t1.rvalid_in_reset", 32'(rvalid_a), 32'd0);
        chk("t1.wen_in_reset", 32'(wen_a), 32'd0);
        next_cyc();
        rst_n = 1'b1; req_a = 2'b00; req_b = 3'b000;
        @(negedge clk);
        chk("t1.gnt_idle", 32'(gnt_a), 32'd0);

        next_cyc();
        req_a = 2'b01; we_a = 2'b01; addr_a = {4'd0, 4'd3}; wdata_a = {8'h00, 8'hA5};
        @(negedge clk);
        chk("t2.wr_gnt", 32'(gnt_a), 32'b01);
        chk("t2.wr_wen", 32'(wen_a), 32'd1);
        chk("t2.wr_ad", 32'(ad_a), 32'd3);
        next_cyc();
        we_a = 2'b00;
        @(negedge clk);
        chk("t2.rd_gnt", 32'(gnt_a), 32'b01);
        chk("t2.rd_no_early_rvalid", 32'(rvalid_a), 32'd0);
        next_cyc();
        req_a = 2'b00;
        @(negedge clk);
        chk("t2.rvalid", 32'(rvalid_a), 32'b01);
        chk("t2.rdata", 32'(rdata_a), 32'hA5);

        next_cyc();
        req_a = 2'b01; we_a = 2'b01; addr_a = {4'd0, 4'd1}; wdata_a = {8'h00, 8'h11};
        next_cyc();
        req_a = 2'b10; we_a = 2'b10; addr_a = {4'd2, 4'd0}; wdata_a = {8'h22, 8'h00};
        next_cyc();
        req_a = 2'b11; we_a = 2'b00; addr_a = {4'd2, 4'd1};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3.gnt_seq", 32'(gnt_a), (k % 2) ? 32'b10 : 32'b01);
            if (k > 0) begin
                chk("t3.rvalid_seq", 32'(rvalid_a), (k % 2) ? 32'b01 : 32'b10);
                chk("t3.rdata_seq", 32'(rdata_a), (k % 2) ? 32'h11 : 32'h22);
            end
            next_cyc();
        end
        req_a = 2'b00;
        @(negedge clk);
        chk("t3.rvalid_last", 32'(rvalid_a), 32'b10);
        chk("t3.rdata_last", 32'(rdata_a), 32'h22);

        next_cyc();
        req_a = 2'b01; we_a = 2'b01; addr_a = {4'd0, 4'd7}; wdata_a = {8'h00, 8'h3C};
        @(negedge clk);
        chk("t5.wr_gnt", 32'(gnt_a), 32'b01);
        next_cyc();
        req_a = 2'b10; we_a = 2'b00; addr_a = {4'd7, 4'd0};
        @(negedge clk);
        chk("t5.rd_gnt", 32'(gnt_a), 32'b10);
        next_cyc();
        req_a = 2'b00;
        @(negedge clk);
        chk("t5.rvalid", 32'(rvalid_a), 32'b10);
        chk("t5.rdata", 32'(rdata_a), 32'h3C);

        next_cyc();
        req_a = 2'b10; we_a = 2'b00; addr_a = {4'd5, 4'd0};
        @(negedge clk);
        chk("t6.rd_gnt", 32'(gnt_a), 32'b10);
        next_cyc();
        req_a = 2'b00; rst_n = 1'b0;
        @(negedge clk);
        chk("t6.rvalid_killed", 32'(rvalid_a), 32'd0);
        next_cyc();
        rst_n = 1'b1; req_a = 2'b11;
        @(negedge clk);
        chk("t6.rvalid_after_release", 32'(rvalid_a), 32'd0);
        chk("t6.first_gnt", 32'(gnt_a), 32'b01);

        next_cyc();
        req_a = 2'b00; req_b = 3'b111; we_b = 3'b000; addr_b = {4'd9, 4'd8, 4'd7};
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4.gnt_order3", 32'(gnt_b), 32'(1 << (k % 3)));
            for (int j = 0; j < 3; j++) if (gnt_b[j]) cnt[j]++;
            next_cyc();
        end
        for (int j = 0; j < 3; j++) chk($sformatf("t4.count%0d", j), 32'(cnt[j]), 32'd2);
        req_b = 3'b101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4.gnt_order_drop1", 32'(gnt_b), (k % 2) ? 32'b100 : 32'b001);
            next_cyc();
        end

        for (int c = 0; c < 500; c++) begin
            next_cyc();
            rst_n   = ($urandom_range(0, 79) != 0);
            req_a   = 2'($urandom);
            we_a    = 2'($urandom);
            addr_a  = 8'($urandom);
            wdata_a = 16'($urandom);
            req_b   = 3'($urandom);
            we_b    = 3'($urandom);
            addr_b  = 12'($urandom);
            wdata_b = 24'($urandom);
        end
        next_cyc();
        rst_n = 1'b1; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port, synchronous-read SRAM (`single_port_syn_read_SRAM`) between n requesters.
- At most one access (read or write) is issued to the SRAM per clock.
- Read data is returned to the issuing requester with a per-requester valid strobe.
- Sits between client blocks and the SRAM instance; it drives the SRAM's w_en/ad/data_in and consumes its data_out.

Parameters:
- w, 8, data width in bits.
- d, 16, SRAM depth in words; address width aw = $clog2(d).
- n, 2, number of requesters; legal range 2..8.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  n  per-requester access request; held until granted.
- we  input  n  per-requester op: 1 = write, 0 = read; valid while req is high.
- addr  input  n*aw  packed addresses; requester i uses bits [i*aw +: aw].
- wdata  input  n*w  packed write data; requester i uses bits [i*w +: w].
- gnt  output  n  one-hot grant (combinational); transfer occurs at the posedge where req[i] & gnt[i].
- rvalid  output  n  one-hot, registered; high for one cycle when rdata belongs to requester i.
- rdata  output  w  read data (mem_data_out passthrough); meaningful only while some rvalid bit is high.
- mem_w_en  output  1  SRAM write enable.
- mem_ad  output  aw  SRAM address.
- mem_data_in  output  w  SRAM write data.
- mem_data_out  input  w  SRAM registered read data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rvalid = 0; internal priority pointer ptr = 0 (requester 0 highest); pending-read tag cleared.
  - gnt = 0 and mem_w_en = 0 while in reset, regardless of req.
- Arbitration, combinational each cycle:
  - Scan requesters starting at ptr, wrapping modulo n; the first i with req[i]=1 wins and gnt = onehot(i).
  - No req: gnt = 0, mem_w_en = 0, mem_ad/mem_data_in hold their last values (no X).
- Issue:
  - mem_ad = addr[i]; mem_data_in = wdata[i]; mem_w_en = we[i] & gnt[i]. All are combinational from the winner.
  - The SRAM samples them at the next posedge.
- Pointer update: on every posedge with a grant, ptr <= (winner+1) mod n. No grant: ptr holds.
- Read latency:
  - A read granted in cycle T produces rvalid[i] = 1 in cycle T+1, with rdata = mem_data_out (SRAM output registered at end of T).
  - Exactly one rvalid pulse per granted read; none for writes.
- Throughput: one access per cycle. Back-to-back reads from different requesters give back-to-back rvalid pulses, each tagged correctly.
- Write then read to the same address in consecutive cycles: the read returns the newly written data (write committed at the earlier posedge).
- Fairness:
  - With all n requesters continuously requesting, each is granted exactly once per n cycles.
  - Worst-case wait is n-1 cycles.
- req deasserted before grant: the request is withdrawn; no side effects, ptr unchanged.
- Reset mid-operation: an in-flight read is dropped (rvalid stays 0 after reset release); ptr returns to 0.
- Width rules: ptr is $clog2(n) bits. The wrap at n-1 -> 0 is explicit, so it is correct for non-power-of-2 n.

Decomposition:
- Shared package sram_pkg:
  - default w/d constants;
  - function clog2-safe address width;
  - function onehot-to-index.
- Sub-module rr_pick (combinational): inputs req[n], ptr; outputs gnt[n] and winner index. Unit-testable alone.
- The top holds ptr, the pending-read tag (valid bit + index), and the SRAM port muxing.

Test Plan:
1. Reset/idle: rst_n low with req=2'b11 -> gnt=0, rvalid=0, mem_w_en=0. Release with req=0 -> gnt stays 0.
2. Single requester, write/read:
   - Req0 writes 8'hA5 to addr 3 -> gnt[0] in the same cycle, mem_w_en=1, mem_ad=3.
   - Req0 then reads addr 3 -> rvalid[0]=1 exactly one cycle later, rdata=8'hA5.
3. Contention:
   - req=2'b11 held for 6 cycles, both reading addrs 1/2 preloaded 8'h11/8'h22.
   - Expected gnt sequence 01,10,01,10,01,10.
   - rvalid alternates one cycle later with rdata 11,22,11,22,...
4. n=3, all requesting:
   - Each gnt bit is seen exactly twice in 6 cycles, order 0,1,2,0,1,2.
   - Drop req[1] -> order becomes 0,2,0,2.
5. Same-address write-then-read:
   - Req0 writes 8'h3C to addr 7 in cycle T; req1 reads addr 7 in T+1.
   - Expected rvalid[1] in T+2 with rdata=8'h3C.
6. Reset mid-read: assert rst_n low in the cycle after a read grant -> no rvalid pulse after release; the first post-reset grant goes to requester 0.
